// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and a buffered multi-cycle result,
// with a destination scoreboard. Define WB_ARB_STATS_EN to enable the conflict_cnt counter.
module wb_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_wb_en,
   input  logic [4:0]  p_rd,
   input  logic [31:0] p_data,
   input  logic        m_valid,
   input  logic [4:0]  m_rd,
   input  logic [31:0] m_data,
   output logic        m_ready,
   input  logic        issue_en,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1_index,
   input  logic [4:0]  rs2_index,
   input  logic        dec_we,
   input  logic [4:0]  dec_rd,
   output logic        stall,
   output logic        wb_hold,
   output logic        wb_en,
   output logic [4:0]  rd_index,
   output logic [31:0] wb_data,
   output logic [15:0] conflict_cnt
);

   localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

   logic        buf_valid_q, buf_valid_d;
   logic [4:0]  buf_rd_q, buf_rd_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic [31:0] pending_q, pending_d;
   logic [3:0]  starve_q, starve_d;

   logic p_write;
   logic drain;
   logic accept;
   logic load;

   always_comb begin
      p_write = p_wb_en && (p_rd != 5'd0);
      wb_hold = buf_valid_q && (starve_q >= StarveMax);
      drain   = buf_valid_q && (!p_write || wb_hold);
      m_ready = !buf_valid_q || drain;
      accept  = m_valid && m_ready;
      load    = accept && (m_rd != 5'd0);
   end

   // Write-port mux: a draining buffer always owns the port.
   always_comb begin
      wb_en    = 1'b0;
      rd_index = 5'd0;
      wb_data  = 32'd0;
      if (drain) begin
         wb_en    = 1'b1;
         rd_index = buf_rd_q;
         wb_data  = buf_data_q;
      end else if (p_write) begin
         wb_en    = 1'b1;
         rd_index = p_rd;
         wb_data  = p_data;
      end
   end

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_rd_d    = buf_rd_q;
      buf_data_d  = buf_data_q;
      if (load) begin
         buf_valid_d = 1'b1;
         buf_rd_d    = m_rd;
         buf_data_d  = m_data;
      end else if (drain) begin
         buf_valid_d = 1'b0;
      end
   end

   always_comb begin
      starve_d = 4'd0;
      if (buf_valid_q && !drain && (starve_q != 4'hF)) begin
         starve_d = starve_q + 4'd1;
      end else if (buf_valid_q && !drain) begin
         starve_d = starve_q;
      end
   end

   // Clear first so a same-cycle issue to the draining index keeps its bit set.
   always_comb begin
      pending_d = pending_q;
      if (drain) begin
         pending_d[buf_rd_q] = 1'b0;
      end
      if (issue_en && (issue_rd != 5'd0)) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      stall = ((rs1_index != 5'd0) && pending_q[rs1_index]) ||
              ((rs2_index != 5'd0) && pending_q[rs2_index]) ||
              (dec_we && (dec_rd != 5'd0) && pending_q[dec_rd]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_rd_q    <= 5'd0;
         buf_data_q  <= 32'd0;
         pending_q   <= 32'd0;
         starve_q    <= 4'd0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_rd_q    <= buf_rd_d;
         buf_data_q  <= buf_data_d;
         pending_q   <= pending_d;
         starve_q    <= starve_d;
      end
   end

`ifdef WB_ARB_STATS_EN
   logic [15:0] conflict_q, conflict_d;

   always_comb begin
      conflict_d = conflict_q;
      if (buf_valid_q && !drain && (conflict_q != 16'hFFFF)) begin
         conflict_d = conflict_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_q <= 16'd0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_cnt = conflict_q;
`else
   assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a set-based reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_wb_arbiter;

   localparam int unsigned SM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_wb_en;
   logic [4:0]  p_rd;
   logic [31:0] p_data;
   logic        m_valid;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic        m_ready;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1_index;
   logic [4:0]  rs2_index;
   logic        dec_we;
   logic [4:0]  dec_rd;
   logic        stall;
   logic        wb_hold;
   logic        wb_en;
   logic [4:0]  rd_index;
   logic [31:0] wb_data;
   logic [15:0] conflict_cnt;

   wb_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .p_wb_en(p_wb_en), .p_rd(p_rd), .p_data(p_data),
      .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
      .issue_en(issue_en), .issue_rd(issue_rd), .rs1_index(rs1_index),
      .rs2_index(rs2_index), .dec_we(dec_we), .dec_rd(dec_rd), .stall(stall),
      .wb_hold(wb_hold), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb_en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        m_ready;
      logic        stall;
      logic        wb_hold;
      logic [15:0] conf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: a waiting result, how long it has waited, and the set of busy registers.
   bit          have_res;
   logic [4:0]  res_rd;
   logic [31:0] res_data;
   int          waited;
   bit          pend[int];
   int          conflicts;
   bit          s_rw;
   bit          s_take;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      have_res  = 0;
      res_rd    = 0;
      res_data  = 0;
      waited    = 0;
      pend.delete();
      conflicts = 0;
   endtask

   function automatic bit busy(input logic [4:0] r);
      return (r != 0) && pend.exists(int'(r));
   endfunction

   task automatic model_eval();
      exp_t e;
      bit pw, hold;
      pw   = p_wb_en && (p_rd != 0);
      hold = have_res && (waited >= int'(SM));
      s_rw = have_res && (!pw || hold);
      e.wb_en   = s_rw || pw;
      e.rd      = s_rw ? res_rd : (pw ? p_rd : 5'd0);
      e.data    = s_rw ? res_data : (pw ? p_data : 32'd0);
      e.m_ready = !have_res || s_rw;
      e.stall   = busy(rs1_index) || busy(rs2_index) || (dec_we && busy(dec_rd));
      e.wb_hold = hold;
`ifdef WB_ARB_STATS_EN
      e.conf    = 16'(conflicts);
`else
      e.conf    = 16'h0;
`endif
      s_take = m_valid && e.m_ready;
      exp_q.push_back(e);
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
         return;
      end
      if (s_rw) pend.delete(int'(res_rd));
      if (issue_en && issue_rd != 0) pend[int'(issue_rd)] = 1;
      if (have_res && !s_rw) begin
         waited++;
         if (conflicts < 65535) conflicts++;
      end else begin
         waited = 0;
      end
      if (s_rw) have_res = 0;
      if (s_take && m_rd != 0) begin
         have_res = 1;
         res_rd   = m_rd;
         res_data = m_data;
      end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic idle_inputs();
      rst = 0; p_wb_en = 0; p_rd = 0; p_data = 0; m_valid = 0; m_rd = 0; m_data = 0;
      issue_en = 0; issue_rd = 0; rs1_index = 0; rs2_index = 0; dec_we = 0; dec_rd = 0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("wb_en", 32'(wb_en), 32'(e.wb_en));
         check("rd_index", 32'(rd_index), 32'(e.rd));
         check("wb_data", wb_data, e.data);
         check("m_ready", 32'(m_ready), 32'(e.m_ready));
         check("stall", 32'(stall), 32'(e.stall));
         check("wb_hold", 32'(wb_hold), 32'(e.wb_hold));
         check("conflict_cnt", 32'(conflict_cnt), 32'(e.conf));
      end
   end

   initial begin
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 0;

      // Issue, hazard, result return and scoreboard release.
      issue_en = 1; issue_rd = 5; step();
      issue_en = 0; rs1_index = 5; step();
      m_valid = 1; m_rd = 5; m_data = 32'hDEADBEEF; step();
      m_valid = 0; step();
      step();
      rs1_index = 0;

      // Starvation: pipeline keeps writing rd 3 while rd 7 waits.
      p_wb_en = 1; p_rd = 3; p_data = 32'h3333_0003;
      m_valid = 1; m_rd = 7; m_data = 32'h7777_0007; step();
      m_valid = 0;
      repeat (8) step();
      p_wb_en = 0; step();

      // Back-to-back results.
      m_valid = 1; m_rd = 8; m_data = 32'h8; step();
      m_rd = 9; m_data = 32'h9; step();
      m_valid = 0; step(); step();

      // Drain and re-issue of the same index.
      issue_en = 1; issue_rd = 4; step();
      issue_en = 0; m_valid = 1; m_rd = 4; m_data = 32'h44; step();
      m_valid = 0; issue_en = 1; issue_rd = 4; rs1_index = 4; step();
      issue_en = 0; step(); step();
      rs1_index = 0;

      // Writes to x0 are dropped.
      m_valid = 1; m_rd = 0; m_data = 32'h1234; p_wb_en = 1; p_rd = 0; step();
      m_valid = 0; step();
      p_wb_en = 0;

      // Reset with a full buffer and a busy register.
      issue_en = 1; issue_rd = 12; step();
      issue_en = 0; p_wb_en = 1; p_rd = 3; m_valid = 1; m_rd = 13; m_data = 32'hD; step();
      m_valid = 0; rs1_index = 12; step();
      rst = 1; step();
      rst = 0; step(); step();
      idle_inputs();

      // Randomised traffic; WB request frozen while a hold is predicted.
      for (int i = 0; i < 3000; i++) begin
         if (!(have_res && waited >= int'(SM))) begin
            p_wb_en = ($urandom_range(0, 3) != 0);
            p_rd    = 5'($urandom_range(0, 7));
            p_data  = $urandom;
         end
         if (!(m_valid && !s_take)) begin
            m_valid = ($urandom_range(0, 2) == 0);
            m_rd    = 5'($urandom_range(0, 7));
            m_data  = $urandom;
         end
         issue_en  = ($urandom_range(0, 3) == 0);
         issue_rd  = 5'($urandom_range(0, 7));
         rs1_index = 5'($urandom_range(0, 7));
         rs2_index = 5'($urandom_range(0, 7));
         dec_we    = $urandom_range(0, 1) == 1;
         dec_rd    = 5'($urandom_range(0, 7));
         rst       = ($urandom_range(0, 199) == 0);
         step();
      end
      idle_inputs();
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
